// File: rtl/cdc_2phase_pkg.sv
// Shared types and constants for the two-phase request/acknowledge crossing.
package cdc_2phase_pkg;

    // Initiator FSM states; StDrain is only reachable in the timeout build.
    typedef enum logic [1:0] {
        StIdle,
        StWaitAck,
        StRspHold,
        StDrain
    } cdc_2phase_state_e;

    localparam int unsigned SyncStagesDefault = 2;
    localparam int unsigned SyncStagesMin     = 2;
    localparam int unsigned SyncStagesMax     = 4;

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level, reset to 0.
module cdc_sync_bit #(
    parameter int unsigned Stages = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    (* async_reg = "true", dont_touch = "true" *) logic [Stages-1:0] sync_q;

    // Shift the asynchronous level through the metastability chain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[Stages-2:0], d_i};
        end
    end

    assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/cdc_2phase_initiator.sv
// Initiator end of a two-phase req/ack crossing: launches one request as a
// level toggle with held data, waits for the ack toggle and returns the
// response on a local valid/ready port.
// Optional feature macro: CDC_2PHASE_INIT_TIMEOUT_EN (ack timeout + drain).
module cdc_2phase_initiator
    import cdc_2phase_pkg::*;
#(
    parameter type         REQ_T          = logic [31:0],
    parameter type         RSP_T          = logic [31:0],
    parameter int unsigned SYNC_STAGES    = SyncStagesDefault,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_valid_i,
    input  REQ_T req_data_i,
    output logic req_ready_o,
    output logic rsp_valid_o,
    output RSP_T rsp_data_o,
    output logic rsp_err_o,
    input  logic rsp_ready_i,
    output logic async_req_o,
    output REQ_T async_data_o,
    input  logic async_ack_i,
    input  RSP_T async_rsp_data_i
);

    if (SYNC_STAGES < SyncStagesMin || SYNC_STAGES > SyncStagesMax ||
        TIMEOUT_CYCLES < 2) begin : gen_param_check
        $error("cdc_2phase_initiator: illegal SYNC_STAGES or TIMEOUT_CYCLES");
    end

    cdc_2phase_state_e state_q;
    logic              ready_q;
    logic              req_q;
    REQ_T              data_q;
    logic              rsp_valid_q;
    RSP_T              rsp_q;
    logic              ack_s;
    logic              ack_match;

`ifdef CDC_2PHASE_INIT_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q;
    // Set only for timeout responses; doubles as "ack may still be pending".
    logic            err_q;
`endif

    cdc_sync_bit #(
        .Stages(SYNC_STAGES)
    ) u_ack_sync (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .d_i  (async_ack_i),
        .q_o  (ack_s)
    );

    // Phases agree when no transaction is outstanding on the crossing.
    assign ack_match = (ack_s == req_q);

    // Transaction FSM; every output is taken straight from a flop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            ready_q     <= 1'b1;
            req_q       <= 1'b0;
            data_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
`ifdef CDC_2PHASE_INIT_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        req_q   <= ~req_q;
                        data_q  <= req_data_i;
                        ready_q <= 1'b0;
                        state_q <= StWaitAck;
`ifdef CDC_2PHASE_INIT_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                StWaitAck: begin
                    if (ack_match) begin
                        rsp_q       <= async_rsp_data_i;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StRspHold;
`ifdef CDC_2PHASE_INIT_TIMEOUT_EN
                        err_q       <= 1'b0;
                    end else if (cnt_q == CntLast) begin
                        rsp_q       <= '0;
                        err_q       <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StRspHold;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
`endif
                    end
                end
                StRspHold: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
`ifdef CDC_2PHASE_INIT_TIMEOUT_EN
                        if (err_q && !ack_match) begin
                            state_q <= StDrain;
                        end else begin
                            state_q <= StIdle;
                            ready_q <= 1'b1;
                        end
`else
                        state_q <= StIdle;
                        ready_q <= 1'b1;
`endif
                    end
                end
`ifdef CDC_2PHASE_INIT_TIMEOUT_EN
                StDrain: begin
                    // Late ack data is discarded; only the phase is resynchronised.
                    if (ack_match) begin
                        state_q <= StIdle;
                        ready_q <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_q     <= StIdle;
                    ready_q     <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o  = ready_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_data_o   = rsp_q;
    assign async_req_o  = req_q;
    assign async_data_o = data_q;
`ifdef CDC_2PHASE_INIT_TIMEOUT_EN
    assign rsp_err_o    = err_q;
`else
    assign rsp_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_2phase_initiator.sv
// Scoreboard bench for cdc_2phase_initiator with a behavioural remote responder.
// Define CDC_2PHASE_INIT_TIMEOUT_EN to also exercise the timeout/drain path.
module tb_cdc_2phase_initiator;

    localparam int unsigned Sync    = 3;
    localparam int unsigned Timeout = 16;
    localparam int          Budget  = 500;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic [31:0] req_data_i;
    logic        req_ready_o;
    logic        rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;
    logic        rsp_ready_i;
    logic        async_req_o;
    logic [31:0] async_data_o;
    logic        async_ack_i;
    logic [31:0] async_rsp_data_i;

    int errors = 0;
    int checks = 0;

    logic [32:0] exp_q[$];
    int          rdy_mode = 0;     // 0 always ready, 1 random, 2 stalled
    int          resp_en = 1;
    int          fixed_delay = -1; // <0: random 0..20
    int          override_en = 0;
    logic [31:0] override_val = '0;
    int          force_req = 0;
    int          ack_events = 0;
    int          n_toggles = 0;
    int          n_accepted = 0;

    cdc_2phase_initiator #(
        .SYNC_STAGES   (Sync),
        .TIMEOUT_CYCLES(Timeout)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .req_data_i      (req_data_i),
        .req_ready_o     (req_ready_o),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_data_o      (rsp_data_o),
        .rsp_err_o       (rsp_err_o),
        .rsp_ready_i     (rsp_ready_i),
        .async_req_o     (async_req_o),
        .async_data_o    (async_data_o),
        .async_ack_i     (async_ack_i),
        .async_rsp_data_i(async_rsp_data_i)
    );

    always #5 clk_i = ~clk_i;

    // Remote responder's transfer function.
    function automatic logic [31:0] rsp_of(input logic [31:0] r);
        return {r[15:0], r[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expire(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound of %0d cycles expired", name, Budget);
    endtask

    // Present one request; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] d, input logic [32:0] exp, input bit push);
        int n;
        n = 0;
        req_valid_i = 1'b1;
        req_data_i  = d;
        forever begin
            @(negedge clk_i);
            if (req_ready_o) break;
            n++;
            if (n > Budget) begin
                expire("send_accept");
                break;
            end
        end
        @(posedge clk_i);
        if (push) exp_q.push_back(exp);
        n_accepted++;
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        forever begin
            @(negedge clk_i);
            if (exp_q.size() == 0 && req_ready_o) break;
            n++;
            if (n > Budget) begin
                expire(name);
                break;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    // Edges from ack toggle until rsp_valid_o is seen, counting the sampling edge.
    task automatic measure_latency(input int start);
        int n;
        int edges;
        n = 0;
        while (ack_events == start && n <= Budget) begin
            @(negedge clk_i);
            n++;
        end
        if (ack_events == start) begin
            expire("latency_ack");
        end else begin
            edges = 0;
            forever begin
                @(posedge clk_i);
                edges++;
                @(negedge clk_i);
                if (rsp_valid_o || edges > Budget) break;
            end
            check("rsp_latency_edges", edges, Sync + 1);
        end
    endtask

    // Responder: answers each new request phase after a delay, resets with the initiator.
    initial begin
        logic [31:0] captured;
        int          d;
        int          forced;
        async_ack_i      = 1'b0;
        async_rsp_data_i = '0;
        forced           = 0;
        forever begin
            @(posedge clk_i);
            #2;
            if (rst_i) begin
                async_ack_i = 1'b0;
            end else if (forced != force_req) begin
                forced           = force_req;
                async_rsp_data_i = 32'hBAAD_0000;
                async_ack_i      = ~async_ack_i;
                ack_events++;
            end else if (resp_en != 0 && async_req_o != async_ack_i) begin
                captured = async_data_o;
                d = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 20));
                repeat (d) @(posedge clk_i);
                #1;
                async_rsp_data_i = (override_en != 0) ? override_val : rsp_of(captured);
                #1;
                check("async_data_held_until_ack", async_data_o, captured);
                async_ack_i = ~async_ack_i;
                ack_events++;
            end
        end
    end

    // Consumer ready pattern.
    initial begin
        rsp_ready_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            case (rdy_mode)
                0:       rsp_ready_i = 1'b1;
                1:       rsp_ready_i = 1'($urandom_range(0, 1));
                default: rsp_ready_i = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on each response handshake, watches the phase rules.
    initial begin
        logic        prev_req;
        logic        prev_ack;
        logic [31:0] prev_data;
        logic [32:0] e;
        prev_req  = 1'b0;
        prev_ack  = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                if (async_req_o != prev_req) begin
                    n_toggles++;
                    check("phase_rule_ack_before_toggle", prev_ack, prev_req);
                end else if (async_data_o != prev_data) begin
                    check("async_data_stable_without_toggle", async_data_o, prev_data);
                end
                if (rsp_valid_o && rsp_ready_i) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_response: got data %0h err %0b, expected none",
                                 rsp_data_o, rsp_err_o);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_data", rsp_data_o, e[31:0]);
                        check("rsp_err", rsp_err_o, e[32]);
                    end
                end
            end
            prev_req  = async_req_o;
            prev_ack  = async_ack_i;
            prev_data = async_data_o;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] snap_data;
        logic        snap_req;
        int          n;
        int          start;
        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        req_data_i  = '0;

        // Reset state.
        repeat (2) @(negedge clk_i);
        check("reset_req_ready", req_ready_o, 1);
        check("reset_async_req", async_req_o, 0);
        check("reset_async_data", async_data_o, 0);
        check("reset_rsp_valid", rsp_valid_o, 0);
        check("reset_rsp_data", rsp_data_o, 0);
        check("reset_rsp_err", rsp_err_o, 0);
        @(posedge clk_i);
        #3 rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Single transaction with a fixed response and latency measurement.
        fixed_delay  = 5;
        override_en  = 1;
        override_val = 32'h1234_5678;
        start        = ack_events;
        send(32'hDEAD_BEEF, {1'b0, 32'h1234_5678}, 1'b1);
        check("wait_ack_not_ready", req_ready_o, 0);
        check("launch_data", async_data_o, 32'hDEAD_BEEF);
        measure_latency(start);
        wait_idle("single_idle");
        override_en = 0;

        // Back-pressure: response must hold while the consumer stalls.
        rdy_mode    = 2;
        fixed_delay = 3;
        d           = $urandom;
        send(d, {1'b0, rsp_of(d)}, 1'b1);
        n = 0;
        while (!rsp_valid_o && n <= Budget) begin
            @(negedge clk_i);
            n++;
        end
        if (!rsp_valid_o) expire("backpressure_rsp");
        snap_data = rsp_data_o;
        snap_req  = async_req_o;
        check("bp_rsp_data_value", snap_data, rsp_of(d));
        repeat (10) begin
            @(negedge clk_i);
            check("bp_rsp_valid_held", rsp_valid_o, 1);
            check("bp_rsp_data_stable", rsp_data_o, snap_data);
            check("bp_req_ready_low", req_ready_o, 0);
            check("bp_async_req_unchanged", async_req_o, snap_req);
        end
        rdy_mode = 0;
        wait_idle("backpressure_idle");

        // Reset in the middle of WAIT_ACK aborts the transaction.
        resp_en = 0;
        send(32'hCAFE_0001, '0, 1'b0);
        repeat (3) @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        check("midreset_req_ready", req_ready_o, 1);
        check("midreset_async_req", async_req_o, 0);
        check("midreset_async_data", async_data_o, 0);
        check("midreset_rsp_valid", rsp_valid_o, 0);
        check("midreset_rsp_data", rsp_data_o, 0);
        check("midreset_rsp_err", rsp_err_o, 0);
        exp_q.delete();
        @(posedge clk_i);
        #3 rst_i = 1'b0;
        @(negedge clk_i);
        check("post_reset_req_ready", req_ready_o, 1);
        resp_en = 1;
        @(posedge clk_i);
        #1;

        // Back-to-back random traffic with random ack delays and consumer stalls.
        fixed_delay = -1;
        rdy_mode    = 1;
        for (int i = 0; i < 100; i++) begin
            d = $urandom;
            send(d, {1'b0, rsp_of(d)}, 1'b1);
        end
        rdy_mode = 0;
        wait_idle("random_idle");
        check("toggle_count", n_toggles, n_accepted);

`ifdef CDC_2PHASE_INIT_TIMEOUT_EN
        // No ack: timeout response, then a late ack absorbed without a second response.
        resp_en = 0;
        send(32'h0BAD_F00D, {1'b1, 32'h0}, 1'b1);
        n = 0;
        forever begin
            @(negedge clk_i);
            if (rsp_valid_o || n > Budget) break;
            n++;
        end
        check("timeout_wait_cycles", n, Timeout);
        check("timeout_rsp_err", rsp_err_o, 1);
        check("timeout_rsp_data", rsp_data_o, 0);
        repeat (40 - Timeout - 2) @(posedge clk_i);
        #1 force_req = force_req + 1;
        @(negedge clk_i);
        check("drain_not_ready", req_ready_o, 0);
        check("drain_no_rsp", rsp_valid_o, 0);
        n = 0;
        while (!req_ready_o && n <= Budget) begin
            @(negedge clk_i);
            n++;
        end
        if (!req_ready_o) expire("drain_exit");
        repeat (4) @(negedge clk_i);
        check("drain_no_late_rsp", rsp_valid_o, 0);
        resp_en = 1;
        fixed_delay = 2;
        @(posedge clk_i);
        #1;
        d = $urandom;
        send(d, {1'b0, rsp_of(d)}, 1'b1);
        wait_idle("after_drain_idle");
`endif

        repeat (5) @(negedge clk_i);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
